// File: rtl/alert_responder_module.sv
// Alert response FSM: blinking alarm lamp, escalating siren and a one-cycle
// clear pulse back to the alert latch on a rising edge of ack.
// Ports: clk/rst (sync active-high), alert (latched level), ack (sync button);
//        alarm_led, siren, clear_alert, state[1:0], event_count[7:0] (all registered).
module alert_responder_module #(
  parameter int BLINK_HALF      = 4,
  parameter int ESCALATE_CYCLES = 20,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alert,
  input  logic       ack,
  output logic       alarm_led,
  output logic       siren,
  output logic       clear_alert,
  output logic [1:0] state,
  output logic [7:0] event_count
);

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int EW = $clog2(ESCALATE_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [EW-1:0] ESC_MAX    = EW'(ESCALATE_CYCLES);
  localparam logic [EW-1:0] ESC_PRE    = EW'(ESCALATE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALARM   = 2'd1,
    CLEAR   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [EW-1:0] esc_q, esc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          led_q, led_d;
  logic          siren_q, siren_d;
  logic          clr_q, clr_d;
  logic          ack_q;
  logic          ack_edge;

  // Only a 0->1 transition acknowledges; a held button never does.
  assign ack_edge = ack & ~ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blink_q <= '0;
      esc_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      siren_q <= 1'b0;
      clr_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      esc_q   <= esc_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      siren_q <= siren_d;
      clr_q   <= clr_d;
      ack_q   <= ack;
    end
  end

  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    esc_d   = esc_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    led_d   = 1'b0;
    siren_d = 1'b0;
    clr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (alert) begin
          state_d = ALARM;
          led_d   = 1'b1;
          blink_d = '0;
          esc_d   = '0;
        end
      end

      ALARM: begin
        if (ack_edge) begin
          // Ack beats a siren assertion on the same edge.
          state_d = CLEAR;
          clr_d   = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else begin
          led_d = led_q;
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            led_d   = ~led_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
          if (esc_q != ESC_MAX) esc_d = esc_q + 1'b1;
          // esc_q counts edges since entry minus one; siren rises on the
          // edge where the count reaches ESCALATE_CYCLES.
          siren_d = (esc_q >= ESC_PRE);
        end
      end

      CLEAR: begin
        state_d = HOLDOFF;
        hold_d  = '0;
      end

      HOLDOFF: begin
        if (hold_q == HOLD_LAST) begin
          if (alert) begin
            state_d = ALARM;
            led_d   = 1'b1;
            blink_d = '0;
            esc_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign state       = state_q;
  assign alarm_led   = led_q;
  assign siren       = siren_q;
  assign clear_alert = clr_q;
  assign event_count = cnt_q;

endmodule

// File: tb/tb_alert_responder_module.sv
module tb_alert_responder_module;

  logic       clk = 1'b0;
  logic       rst;
  logic       alert;
  logic       ack;
  logic       alarm_led;
  logic       siren;
  logic       clear_alert;
  logic [1:0] state;
  logic [7:0] event_count;

  int checks   = 0;
  int failures = 0;

  alert_responder_module #(
    .BLINK_HALF(4),
    .ESCALATE_CYCLES(20),
    .HOLDOFF_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alert(alert),
    .ack(ack),
    .alarm_led(alarm_led),
    .siren(siren),
    .clear_alert(clear_alert),
    .state(state),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called right after the ack edge: walks CLEAR->HOLDOFF, optionally raises
  // alert mid-holdoff, and checks the decision edge outcome.
  task automatic holdoff(input logic mid_alert, input logic final_alert);
    ack   = 1'b0;
    alert = 1'b0;
    tick();
    check("hold_entry_state", state, 3);
    check("hold_entry_clear", clear_alert, 0);
    for (int j = 1; j <= 7; j++) begin
      if (j == 3) alert = mid_alert;
      tick();
      check("hold_state", state, 3);
      check("hold_led", alarm_led, 0);
      check("hold_siren", siren, 0);
    end
    alert = final_alert;
    tick();
    check("hold_decision", state, final_alert ? 1 : 0);
    check("hold_decision_led", alarm_led, final_alert);
  endtask

  initial begin
    // 1. Reset with alert and ack both high
    rst = 1'b1; alert = 1'b1; ack = 1'b1;
    tick();
    tick();
    check("rst_state", state, 0);
    check("rst_led", alarm_led, 0);
    check("rst_siren", siren, 0);
    check("rst_clear", clear_alert, 0);
    check("rst_count", event_count, 0);
    rst = 1'b0;
    tick();
    check("rel_state", state, 1);
    check("rel_led", alarm_led, 1);

    // 4a. ack held high since before the alarm: never acknowledges
    for (int k = 1; k <= 25; k++) begin
      tick();
      check("held_state", state, 1);
    end
    check("held_siren", siren, 1);
    check("held_count", event_count, 0);
    ack = 1'b0;
    tick();
    check("ackfall_state", state, 1);
    ack = 1'b1;
    tick();
    check("ack1_state", state, 2);
    check("ack1_clear", clear_alert, 1);
    check("ack1_siren", siren, 0);
    check("ack1_led", alarm_led, 0);
    check("ack1_count", event_count, 1);
    holdoff(1'b0, 1'b0);

    // 2. Blink pattern then ack at edge 10
    alert = 1'b1;
    tick();
    check("blink_state", state, 1);
    check("blink_e0", alarm_led, 1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("blink_led", alarm_led, ((k / 4) % 2) == 0);
      check("blink_siren", siren, 0);
    end
    ack = 1'b1;
    tick();
    check("ack2_state", state, 2);
    check("ack2_clear", clear_alert, 1);
    check("ack2_count", event_count, 2);
    check("ack2_siren", siren, 0);

    // 5a. alert re-asserted during holdoff: ignored, then re-trigger
    holdoff(1'b1, 1'b1);

    // 3. Escalation from the re-triggered alarm, ack at edge 30
    for (int k = 1; k <= 29; k++) begin
      tick();
      check("esc_siren", siren, k >= 20);
      check("esc_led", alarm_led, ((k / 4) % 2) == 0);
    end
    ack = 1'b1;
    tick();
    check("ack3_siren", siren, 0);
    check("ack3_state", state, 2);
    check("ack3_count", event_count, 3);
    holdoff(1'b0, 1'b0);

    // 4b. alert+ack together in IDLE, then ack tie at edge 20
    alert = 1'b1; ack = 1'b1;
    tick();
    check("tie_idle_state", state, 1);
    check("tie_idle_count", event_count, 3);
    ack = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      check("tie_siren", siren, 0);
    end
    ack = 1'b1;
    tick();
    check("tie_state", state, 2);
    check("tie_siren_e20", siren, 0);
    check("tie_count", event_count, 4);
    holdoff(1'b0, 1'b0);

    // Reset mid-ALARM: no clear pulse, ALARM re-entered while alert stays 1
    alert = 1'b1;
    tick();
    check("mid_alarm_state", state, 1);
    rst = 1'b1;
    tick();
    check("midrst_state", state, 0);
    check("midrst_clear", clear_alert, 0);
    check("midrst_count", event_count, 0);
    rst = 1'b0;
    tick();
    check("midrst_reenter", state, 1);

    // 6. Saturation over 257 alarm/ack rounds
    rst = 1'b1;
    tick();
    rst = 1'b0; ack = 1'b0; alert = 1'b0;
    for (int i = 0; i < 257; i++) begin
      alert = 1'b1;
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0; alert = 1'b0;
      if (i == 0) check("sat_first", event_count, 1);
      if (i == 254) check("sat_255", event_count, 255);
      repeat (9) tick();
    end
    check("sat_final", event_count, 255);
    check("sat_idle", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alert_responder_module.md
# alert_responder_module

Consumes the latched `q` output of the alert latch and drives the operator-facing response: a blinking alarm lamp, an escalating siren, and a one-cycle clear pulse back to the latch's `rst` input once the operator acknowledges. It is the response end of the alert path, sitting between the alert latch and the panel I/O. It also keeps a saturating count of acknowledged events.

## Interface
Parameters:
- `BLINK_HALF`, default 4: cycles per lamp half-period; must be ≥1.
- `ESCALATE_CYCLES`, default 20: unacknowledged cycles in ALARM before the siren asserts; must be ≥1.
- `HOLDOFF_CYCLES`, default 8: cycles in HOLDOFF during which `alert` is ignored; must be ≥1.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `alert`, input, 1: latched alert level, driven by the alert latch `q`.
- `ack`, input, 1: operator acknowledge button, already synchronous to `clk`.
- `alarm_led`, output, 1: blinking lamp.
- `siren`, output, 1: escalation output.
- `clear_alert`, output, 1: one-cycle pulse, wired to the alert latch `rst`.
- `state`, output, 2: current state. IDLE=0, ALARM=1, CLEAR=2, HOLDOFF=3.
- `event_count`, output, 8: number of acknowledged alarms, saturating at 255.

## Operation
- **Reset:** all outputs are registered. On an edge with `rst`=1:
  - state goes to IDLE.
  - `alarm_led`=0, `siren`=0, `clear_alert`=0, `event_count`=0.
  - All internal counters and the `ack` history register are cleared.
  - Reset overrides every other input on that edge.
- **Ack detection:** an acknowledge is a rising edge of `ack`, i.e. `ack`=1 this edge and `ack`=0 on the previous edge. Holding `ack` high therefore never acknowledges a later alarm.
- **IDLE:** all outputs are 0.
  - `alert`=1 moves to ALARM.
  - Ack edges are ignored.
- **ALARM:**
  - On entry, `alarm_led`=1 and blink/escalation counters are 0.
  - Lamp toggles every `BLINK_HALF` cycles.
  - Escalation counter increments each cycle and saturates at `ESCALATE_CYCLES`. When it reaches `ESCALATE_CYCLES`, `siren` goes to 1 and stays 1 while in ALARM.
  - An ack edge moves to CLEAR. On that edge: `alarm_led`=0, `siren`=0, `clear_alert`=1, and `event_count` increments unless it is already 255.
  - If `alert` drops while in ALARM, the block stays in ALARM; only an ack leaves.
- **CLEAR:** lasts exactly one cycle with `clear_alert`=1, then moves unconditionally to HOLDOFF with `clear_alert`=0.
- **HOLDOFF:**
  - `alert` and ack edges are ignored; all lamp/siren/clear outputs are 0.
  - After `HOLDOFF_CYCLES` cycles, the next state is ALARM if `alert`=1, otherwise IDLE. The ALARM case is a re-trigger, meaning the condition persisted.
- **Simultaneous events:**
  - Ack on the same edge the siren would assert: ack wins, `siren` stays 0.
  - `alert` and ack edge together in IDLE: enter ALARM, ack ignored.

## Timing
- Latency from IDLE to alarm: `alert` sampled 1 at edge E gives `state`=1 and `alarm_led`=1 after E.
- Lamp: high for cycles E+1..E+`BLINK_HALF`, low for the next `BLINK_HALF` cycles, and so on. Duty cycle is exactly 50%.
- `siren` first goes high after edge E+`ESCALATE_CYCLES`, provided no ack edge occurred at or before that edge.
- Ack edge sampled at edge A (in ALARM):
  - `clear_alert` is high for the single cycle after A.
  - HOLDOFF is entered at A+1.
  - The IDLE/ALARM decision is made at edge A+1+`HOLDOFF_CYCLES`.
- The alert latch clears on the edge after A, so `alert` is 0 throughout HOLDOFF unless the condition re-fires.
- Reset mid-ALARM or mid-CLEAR: IDLE after that edge and no `clear_alert` pulse. The alert latch is not cleared; if `alert` is still 1, ALARM is re-entered on the following edge.

## Test plan
All scenarios use `BLINK_HALF`=4, `ESCALATE_CYCLES`=20, `HOLDOFF_CYCLES`=8.
1. **Reset values:** assert `rst` for 2 cycles with `alert`=1 and `ack`=1 → all outputs 0 and `state`=0. On release, ALARM is entered on the next edge.
2. **Alarm then ack:** `alert`=1 at edge 0 → `alarm_led` pattern 1111 0000 1111 from cycle 1. Pulse `ack` at edge 10 → `state`=2 and `clear_alert`=1 for exactly one cycle, `event_count`=1, `siren` never 1.
3. **Escalation:** `alert`=1 at edge 0 with no ack → `siren`=0 through cycle 19 and 1 from cycle 20 on. Ack at edge 30 → `siren`=0 after edge 30.
4. **Held ack and ack tie:**
   - `ack` held high since before the alarm → no acknowledge occurs; the block stays in ALARM until `ack` falls and rises again.
   - Ack edge exactly at edge 20 → `siren` stays 0.
5. **Holdoff re-trigger:**
   - Re-assert `alert` during HOLDOFF → ignored; `state`=3 for exactly 8 cycles, then ALARM because `alert`=1.
   - Same run with `alert`=0 at the decision edge → IDLE.
6. **Counter saturation:** run 257 alarm/ack cycles → `event_count` reads 255, no wrap to 0.
